// File: rtl/video_timing_gen.sv
// Raster timing generator for a progressive PAL composite output: beam counters,
// pixel/line strobes, visibility flags and sync/burst gating, all registered and aligned.
module video_timing_gen #(
  parameter int CLKS_PER_LINE   = 3072,
  parameter int LINES_PER_FIELD = 312,
  parameter int HSYNC_CLKS      = 226,
  parameter int BURST_START     = 269,
  parameter int BURST_CLKS      = 108,
  parameter int VSYNC_LINES     = 3,
  parameter int WINDOW_START    = 600,
  parameter int PIXEL_DIV       = 9,
  parameter int WINDOW_PIXELS   = 256,
  parameter int VIS_FIRST_LINE  = 40,
  parameter int VIS_LINES       = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [12:0] video_x,
  output logic [8:0]  video_y,
  output logic        newline,
  output logic        newpixel,
  output logic        field_start,
  output logic        visible_line,
  output logic        visible_window,
  output logic        sync,
  output logic        burst_gate
);

  localparam int WINDOW_END = WINDOW_START + WINDOW_PIXELS * PIXEL_DIV;
  localparam int DIV_W      = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;

  localparam logic [12:0]      X_LAST      = 13'(CLKS_PER_LINE - 1);
  localparam logic [8:0]       Y_LAST      = 9'(LINES_PER_FIELD - 1);
  localparam logic [12:0]      X_DIV_CLEAR = 13'(WINDOW_START);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(PIXEL_DIV - 1);

  // Thresholds are one bit wider than the counters so a bound equal to the
  // full line/field length still compares correctly.
  localparam logic [13:0] X_WIN_BEGIN   = 14'(WINDOW_START);
  localparam logic [13:0] X_WIN_END     = 14'(WINDOW_END);
  localparam logic [13:0] X_HSYNC_END   = 14'(HSYNC_CLKS);
  localparam logic [13:0] X_HALF        = 14'(CLKS_PER_LINE / 2);
  localparam logic [13:0] X_BROAD1_END  = 14'(CLKS_PER_LINE / 2 - HSYNC_CLKS);
  localparam logic [13:0] X_BROAD2_END  = 14'(CLKS_PER_LINE - HSYNC_CLKS);
  localparam logic [13:0] X_BURST_BEGIN = 14'(BURST_START);
  localparam logic [13:0] X_BURST_END   = 14'(BURST_START + BURST_CLKS);
  localparam logic [9:0]  Y_VSYNC_END   = 10'(VSYNC_LINES);
  localparam logic [9:0]  Y_VIS_BEGIN   = 10'(VIS_FIRST_LINE);
  localparam logic [9:0]  Y_VIS_END     = 10'(VIS_FIRST_LINE + VIS_LINES);

  if (WINDOW_END > CLKS_PER_LINE) begin : g_window_check
    $error("visible window does not fit in the line");
  end
  if (BURST_START + BURST_CLKS > WINDOW_START) begin : g_burst_check
    $error("burst gate overlaps the visible window");
  end
  if (CLKS_PER_LINE > 8192 || LINES_PER_FIELD > 512) begin : g_size_check
    $error("line or field length exceeds counter width");
  end

  typedef enum logic {NORMAL, BROAD} line_state_t;

  line_state_t      state_reg, state_next;
  logic [12:0]      x_reg, x_next;
  logic [8:0]       y_reg, y_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [13:0]      x_ext;
  logic [9:0]       y_ext;

  logic newline_reg, newpixel_reg, field_start_reg, visible_line_reg;
  logic visible_window_reg, sync_reg, burst_gate_reg;
  logic newline_next, newpixel_next, field_start_next, visible_line_next;
  logic visible_window_next, sync_next, burst_gate_next;

  always_comb begin
    x_next = x_reg + 13'd1;
    y_next = y_reg;
    if (x_reg == X_LAST) begin
      x_next = '0;
      y_next = (y_reg == Y_LAST) ? '0 : y_reg + 9'd1;
    end
    x_ext = {1'b0, x_next};
    y_ext = {1'b0, y_next};
  end

  // Divider phase restarts at the window's first clock so pixel edges line up with it.
  always_comb begin
    if (x_next == X_DIV_CLEAR || div_reg == DIV_LAST) begin
      div_next = '0;
    end else begin
      div_next = div_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    sync_next  = 1'b0;
    if (x_next == 13'd0) begin
      state_next = (y_ext < Y_VSYNC_END) ? BROAD : NORMAL;
    end
    case (state_next)
      NORMAL: sync_next = (x_ext < X_HSYNC_END);
      BROAD:  sync_next = (x_ext < X_BROAD1_END) ||
                          (x_ext >= X_HALF && x_ext < X_BROAD2_END);
      default: sync_next = 1'b0;
    endcase
  end

  always_comb begin
    newline_next        = (x_next == 13'd0);
    field_start_next    = newline_next && (y_next == 9'd0);
    visible_line_next   = (y_ext >= Y_VIS_BEGIN) && (y_ext < Y_VIS_END);
    visible_window_next = visible_line_next && (x_ext >= X_WIN_BEGIN) && (x_ext < X_WIN_END);
    newpixel_next       = visible_window_next && (div_next == DIV_LAST);
    burst_gate_next     = (y_ext >= Y_VSYNC_END) &&
                          (x_ext >= X_BURST_BEGIN) && (x_ext < X_BURST_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= NORMAL;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg              <= X_LAST;
      y_reg              <= Y_LAST;
      div_reg            <= '0;
      newline_reg        <= 1'b0;
      newpixel_reg       <= 1'b0;
      field_start_reg    <= 1'b0;
      visible_line_reg   <= 1'b0;
      visible_window_reg <= 1'b0;
      sync_reg           <= 1'b0;
      burst_gate_reg     <= 1'b0;
    end else begin
      x_reg              <= x_next;
      y_reg              <= y_next;
      div_reg            <= div_next;
      newline_reg        <= newline_next;
      newpixel_reg       <= newpixel_next;
      field_start_reg    <= field_start_next;
      visible_line_reg   <= visible_line_next;
      visible_window_reg <= visible_window_next;
      sync_reg           <= sync_next;
      burst_gate_reg     <= burst_gate_next;
    end
  end

  assign video_x        = x_reg;
  assign video_y        = y_reg;
  assign newline        = newline_reg;
  assign newpixel       = newpixel_reg;
  assign field_start    = field_start_reg;
  assign visible_line   = visible_line_reg;
  assign visible_window = visible_window_reg;
  assign sync           = sync_reg;
  assign burst_gate     = burst_gate_reg;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen using a scaled raster so whole fields fit in a short run;
// outputs are compared against an arithmetic model indexed by clocks since reset release.
module tb_video_timing_gen;

  localparam int CPL   = 256;
  localparam int LPF   = 40;
  localparam int HS    = 20;
  localparam int BS    = 24;
  localparam int BC    = 10;
  localparam int VS    = 3;
  localparam int WS    = 40;
  localparam int PD    = 3;
  localparam int WP    = 64;
  localparam int VFL   = 8;
  localparam int VL    = 24;
  localparam int FIELD = CPL * LPF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] video_x;
  logic [8:0]  video_y;
  logic        newline, newpixel, field_start, visible_line, visible_window, sync, burst_gate;
  logic [28:0] obs;
  logic [7:0]  pixel_x;

  int tests = 0;
  int fails = 0;
  int t = -1;

  video_timing_gen #(
    .CLKS_PER_LINE(CPL), .LINES_PER_FIELD(LPF), .HSYNC_CLKS(HS), .BURST_START(BS),
    .BURST_CLKS(BC), .VSYNC_LINES(VS), .WINDOW_START(WS), .PIXEL_DIV(PD),
    .WINDOW_PIXELS(WP), .VIS_FIRST_LINE(VFL), .VIS_LINES(VL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .video_x(video_x), .video_y(video_y),
    .newline(newline), .newpixel(newpixel), .field_start(field_start),
    .visible_line(visible_line), .visible_window(visible_window),
    .sync(sync), .burst_gate(burst_gate)
  );

  always #5 clk = ~clk;

  assign obs = {video_x, video_y, newline, newpixel, field_start,
                visible_line, visible_window, sync, burst_gate};

  // Downstream pixel counter as a consumer of newline/newpixel would build it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pixel_x <= 8'd0;
    else if (newline)  pixel_x <= 8'd0;
    else if (newpixel) pixel_x <= pixel_x + 8'd1;
  end

  function automatic logic [28:0] model(input int tc);
    int x, y;
    logic nl, np, fs, vl, vw, sy, bg;
    x  = tc % CPL;
    y  = (tc / CPL) % LPF;
    nl = (x == 0);
    fs = nl && (y == 0);
    vl = (y >= VFL) && (y < VFL + VL);
    vw = vl && (x >= WS) && (x < WS + WP * PD);
    np = vw && (((x - WS) % PD) == PD - 1);
    if (y < VS) sy = (x < CPL / 2 - HS) || (x >= CPL / 2 && x < CPL - HS);
    else        sy = (x < HS);
    bg = (y >= VS) && (x >= BS) && (x < BS + BC);
    return {13'(x), 9'(y), nl, np, fs, vl, vw, sy, bg};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  function automatic bit at_pos(input int ty, input int tx);
    return (t >= 0) && (t % CPL == tx) && ((t / CPL) % LPF == ty);
  endfunction

  // Runs to the start of line ty and gathers per-line statistics over it.
  task automatic measure_line(input int ty, output int nl_cnt, output int vw_cnt,
                              output int np_cnt, output int first_np, output int sync_cnt,
                              output int burst_cnt, output int pix_err, output int vw_first,
                              output int burst_first);
    int prev_y;
    prev_y = (ty + LPF - 1) % LPF;
    for (int i = 0; i <= FIELD && !at_pos(prev_y, CPL - 1); i++) step();
    nl_cnt = 0; vw_cnt = 0; np_cnt = 0; first_np = -1; sync_cnt = 0;
    burst_cnt = 0; pix_err = 0; vw_first = -1; burst_first = -1;
    for (int i = 0; i < CPL; i++) begin
      step();
      nl_cnt    += int'(newline);
      vw_cnt    += int'(visible_window);
      sync_cnt  += int'(sync);
      burst_cnt += int'(burst_gate);
      if (newpixel) begin
        np_cnt++;
        if (first_np < 0) first_np = int'(video_x);
      end
      if (visible_window && vw_first < 0) vw_first = int'(video_x);
      if (burst_gate && burst_first < 0) burst_first = int'(video_x);
      if (visible_window && int'(pixel_x) != (int'(video_x) - WS) / PD) pix_err++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (video_x !== 13'(CPL - 1)) begin
      fails++; $display("FAIL reset_x: got %0d expected %0d", video_x, CPL - 1);
    end
    tests++;
    if (video_y !== 9'(LPF - 1)) begin
      fails++; $display("FAIL reset_y: got %0d expected %0d", video_y, LPF - 1);
    end
    tests++;
    if (obs[6:0] !== 7'b0) begin
      fails++; $display("FAIL reset_flags: got %b expected 0000000", obs[6:0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    t = -1;
    step();
    tests++;
    if ({video_x, video_y, newline, field_start, sync, burst_gate, visible_window}
        !== {13'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL first_cycle: got x=%0d y=%0d nl=%b fs=%b sync=%b burst=%b vw=%b expected x=0 y=0 nl=1 fs=1 sync=1 burst=0 vw=0",
               video_x, video_y, newline, field_start, sync, burst_gate, visible_window);
    end
  endtask

  task automatic test_full_field();
    int nl_cnt, fs_cnt, mism;
    nl_cnt = int'(newline);
    fs_cnt = int'(field_start);
    mism = 0;
    while (t < FIELD - 1) begin
      step();
      nl_cnt += int'(newline);
      fs_cnt += int'(field_start);
      tests++;
      if (obs !== model(t)) begin
        fails++; mism++;
        if (mism <= 5) $display("FAIL field_cycle t=%0d: got %h expected %h", t, obs, model(t));
      end
    end
    tests++;
    if (nl_cnt != LPF) begin
      fails++; $display("FAIL newline_count: got %0d expected %0d", nl_cnt, LPF);
    end
    tests++;
    if (fs_cnt != 1) begin
      fails++; $display("FAIL field_start_count: got %0d expected 1", fs_cnt);
    end
    step();
    tests++;
    if ({field_start, video_x, video_y} !== {1'b1, 13'd0, 9'd0}) begin
      fails++;
      $display("FAIL field_period: got fs=%b x=%0d y=%0d expected fs=1 x=0 y=0 at t=%0d",
               field_start, video_x, video_y, FIELD);
    end
  endtask

  task automatic test_lines();
    int nl, vw, np, fnp, sc, bc, pe, vwf, bf;
    measure_line(1, nl, vw, np, fnp, sc, bc, pe, vwf, bf);
    tests++;
    if (sc != CPL - 2 * HS || bc != 0) begin
      fails++; $display("FAIL broad_line: got sync=%0d burst=%0d expected sync=%0d burst=0", sc, bc, CPL - 2 * HS);
    end
    measure_line(VS, nl, vw, np, fnp, sc, bc, pe, vwf, bf);
    tests++;
    if (sc != HS || bc != BC || bf != BS) begin
      fails++;
      $display("FAIL normal_line: got sync=%0d burst=%0d burst_first=%0d expected %0d %0d %0d",
               sc, bc, bf, HS, BC, BS);
    end
    measure_line(VFL - 1, nl, vw, np, fnp, sc, bc, pe, vwf, bf);
    tests++;
    if (vw != 0 || np != 0) begin
      fails++; $display("FAIL line_before_visible: got vw=%0d np=%0d expected 0 0", vw, np);
    end
    measure_line(VFL, nl, vw, np, fnp, sc, bc, pe, vwf, bf);
    tests++;
    if (vw != WP * PD || vwf != WS) begin
      fails++; $display("FAIL window_span: got len=%0d first=%0d expected %0d %0d", vw, vwf, WP * PD, WS);
    end
    tests++;
    if (np != WP || fnp != WS + PD - 1) begin
      fails++; $display("FAIL newpixel_count: got n=%0d first=%0d expected %0d %0d", np, fnp, WP, WS + PD - 1);
    end
    tests++;
    if (pe != 0) begin
      fails++; $display("FAIL pixel_counter: got %0d bad cycles expected 0", pe);
    end
    measure_line(VFL + VL, nl, vw, np, fnp, sc, bc, pe, vwf, bf);
    tests++;
    if (vw != 0 || np != 0) begin
      fails++; $display("FAIL line_after_visible: got vw=%0d np=%0d expected 0 0", vw, np);
    end
  endtask

  task automatic test_random_reset();
    int ty, tx, mism;
    for (int r = 0; r < 3; r++) begin
      if (r == 0) begin ty = VFL + 5; tx = WS + 7; end
      else begin ty = $urandom_range(LPF - 1, 0); tx = $urandom_range(CPL - 1, 0); end
      for (int i = 0; i <= FIELD && !at_pos(ty, tx); i++) step();
      #3;
      rst_n = 1'b0;
      #1;
      tests++;
      if (obs !== {13'(CPL - 1), 9'(LPF - 1), 7'b0}) begin
        fails++; $display("FAIL async_reset y=%0d x=%0d: got %h expected %h", ty, tx, obs,
                          {13'(CPL - 1), 9'(LPF - 1), 7'b0});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      t = -1;
      mism = 0;
      for (int i = 0; i < CPL * 12; i++) begin
        step();
        tests++;
        if (obs !== model(t)) begin
          fails++; mism++;
          if (mism <= 5) $display("FAIL restart_cycle t=%0d: got %h expected %h", t, obs, model(t));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_field();
    test_lines();
    test_random_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
